// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART.
//   OVERSAMPLE : ticks per bit for start, data and parity bits
//   par_mode_t : parity selection as presented on the par_mode port
//   tx_state_t : transmitter FSM states
//   rx_state_t : receiver FSM states
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      PAR_NONE     = 2'b00,
      PAR_EVEN     = 2'b01,
      PAR_ODD      = 2'b10,
      PAR_NONE_ALT = 2'b11
   } par_mode_t;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   function automatic logic par_enabled(input par_mode_t mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   br_div : tick period minus one, in clk cycles
//   tick   : one-cycle pulse on the cycle the counter wraps
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] br_div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // ">=" rather than "==" so a count already past a freshly lowered
   // divisor wraps immediately instead of rolling all the way round.
   assign tick = (cnt >= br_div);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_cfg_top.sv
// Configurable UART: baud tick generator plus independent TX and RX FSMs.
//   clk, rst   : system clock, asynchronous active-low reset
//   br_div     : tick period minus one (tick = 16x baud)
//   par_mode   : 00/11 none, 01 even, 10 odd
//   lb         : loopback, receiver fed from internal tx
//   tx_start   : send din (honoured only while idle)
//   din        : transmit data
//   tx         : serial out, idle high
//   tx_busy    : transmitter active
//   tx_done    : one-cycle pulse at end of stop bit
//   rx         : serial in, asynchronous
//   dout       : last received data
//   rx_done    : one-cycle pulse per received frame
//   parity_err : parity mismatch on last frame
//   frame_err  : stop bit sampled low on last frame
//
// TX states
//   state     | meaning
//   TX_IDLE   | line high, waiting for tx_start
//   TX_START  | start bit (0) for 16 ticks
//   TX_DATA   | data bits LSB first, 16 ticks each
//   TX_PARITY | parity bit for 16 ticks (skipped when parity off)
//   TX_STOP   | line high for SB_TICKS ticks, then tx_done
//
// RX states
//   state     | meaning
//   RX_IDLE   | waiting for a low line
//   RX_START  | line must still be low 8 ticks later (mid start bit)
//   RX_DATA   | sample each data bit every 16 ticks (mid bit)
//   RX_PARITY | sample parity bit
//   RX_STOP   | sample stop after SB_TICKS ticks, publish results
module uart_cfg_top
   import uart_pkg::*;
#(
   parameter int DBITS    = 8,
   parameter int SB_TICKS = 16,
   parameter int DIV_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] br_div,
   input  logic [1:0]       par_mode,
   input  logic             lb,
   input  logic             tx_start,
   input  logic [DBITS-1:0] din,
   output logic             tx,
   output logic             tx_busy,
   output logic             tx_done,
   input  logic             rx,
   output logic [DBITS-1:0] dout,
   output logic             rx_done,
   output logic             parity_err,
   output logic             frame_err
);

   localparam int TC_MAX = (SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE;
   localparam int TC_W   = $clog2(TC_MAX);
   localparam int BC_W   = $clog2(DBITS);

   localparam logic [TC_W-1:0] TC_BIT  = TC_W'(OVERSAMPLE - 1);
   localparam logic [TC_W-1:0] TC_HALF = TC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TC_W-1:0] TC_STOP = TC_W'(SB_TICKS - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DBITS - 1);

   par_mode_t pm_in;
   logic      tick;

   assign pm_in = par_mode_t'(par_mode);

   uart_baud_gen #(
      .DIV_W (DIV_W)
   ) u_baud_gen (
      .clk    (clk),
      .rst    (rst),
      .br_div (br_div),
      .tick   (tick)
   );

   // ---------------------------------------------------------------- TX

   tx_state_t        tx_state, tx_state_nxt;
   logic [TC_W-1:0]  tx_tcnt, tx_tcnt_nxt;
   logic [BC_W-1:0]  tx_bcnt, tx_bcnt_nxt;
   logic [DBITS-1:0] tx_sr, tx_sr_nxt;
   logic             tx_par_en, tx_par_en_nxt;
   logic             tx_par_bit, tx_par_bit_nxt;
   logic             tx_done_nxt;
   logic             tx_tc;

   // Tick counters count down; a state ends on the tick seen at zero.
   assign tx_tc = tick && (tx_tcnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state   <= TX_IDLE;
         tx_tcnt    <= '0;
         tx_bcnt    <= '0;
         tx_sr      <= '0;
         tx_par_en  <= 1'b0;
         tx_par_bit <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_state   <= tx_state_nxt;
         tx_tcnt    <= tx_tcnt_nxt;
         tx_bcnt    <= tx_bcnt_nxt;
         tx_sr      <= tx_sr_nxt;
         tx_par_en  <= tx_par_en_nxt;
         tx_par_bit <= tx_par_bit_nxt;
         tx_done    <= tx_done_nxt;
      end
   end

   always_comb begin
      tx_state_nxt   = tx_state;
      tx_tcnt_nxt    = tx_tcnt;
      tx_bcnt_nxt    = tx_bcnt;
      tx_sr_nxt      = tx_sr;
      tx_par_en_nxt  = tx_par_en;
      tx_par_bit_nxt = tx_par_bit;
      tx_done_nxt    = 1'b0;

      if ((tx_state != TX_IDLE) && tick && (tx_tcnt != '0)) begin
         tx_tcnt_nxt = tx_tcnt - TC_W'(1);
      end

      case (tx_state)
         TX_IDLE: begin
            if (tx_start) begin
               tx_state_nxt   = TX_START;
               tx_tcnt_nxt    = TC_BIT;
               tx_sr_nxt      = din;
               tx_par_en_nxt  = par_enabled(pm_in);
               tx_par_bit_nxt = (^din) ^ (pm_in == PAR_ODD);
            end
         end
         TX_START: begin
            if (tx_tc) begin
               tx_state_nxt = TX_DATA;
               tx_tcnt_nxt  = TC_BIT;
               tx_bcnt_nxt  = BC_LAST;
            end
         end
         TX_DATA: begin
            if (tx_tc) begin
               tx_sr_nxt   = tx_sr >> 1;
               tx_tcnt_nxt = TC_BIT;
               if (tx_bcnt == '0) begin
                  tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
                  tx_tcnt_nxt  = tx_par_en ? TC_BIT : TC_STOP;
               end else begin
                  tx_bcnt_nxt = tx_bcnt - BC_W'(1);
               end
            end
         end
         TX_PARITY: begin
            if (tx_tc) begin
               tx_state_nxt = TX_STOP;
               tx_tcnt_nxt  = TC_STOP;
            end
         end
         TX_STOP: begin
            if (tx_tc) begin
               tx_state_nxt = TX_IDLE;
               tx_done_nxt  = 1'b1;
            end
         end
         default: begin
            tx_state_nxt = TX_IDLE;
         end
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (tx_state)
         TX_START:  tx = 1'b0;
         TX_DATA:   tx = tx_sr[0];
         TX_PARITY: tx = tx_par_bit;
         default:   tx = 1'b1;
      endcase
   end

   assign tx_busy = (tx_state != TX_IDLE);

   // ---------------------------------------------------------------- RX

   logic [1:0] sync;
   logic       rx_line;

   // Loopback is selected ahead of the synchroniser so both paths see
   // identical latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= 2'b11;
      end else begin
         sync <= {sync[0], (lb ? tx : rx)};
      end
   end

   assign rx_line = sync[1];

   rx_state_t        rx_state, rx_state_nxt;
   logic [TC_W-1:0]  rx_tcnt, rx_tcnt_nxt;
   logic [BC_W-1:0]  rx_bcnt, rx_bcnt_nxt;
   logic [DBITS-1:0] rx_sr, rx_sr_nxt;
   logic             rx_par_en, rx_par_en_nxt;
   logic             rx_par_odd, rx_par_odd_nxt;
   logic             rx_perr, rx_perr_nxt;
   logic [DBITS-1:0] dout_nxt;
   logic             parity_err_nxt, frame_err_nxt, rx_done_nxt;
   logic             rx_tc;

   assign rx_tc = tick && (rx_tcnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state   <= RX_IDLE;
         rx_tcnt    <= '0;
         rx_bcnt    <= '0;
         rx_sr      <= '0;
         rx_par_en  <= 1'b0;
         rx_par_odd <= 1'b0;
         rx_perr    <= 1'b0;
         dout       <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         rx_done    <= 1'b0;
      end else begin
         rx_state   <= rx_state_nxt;
         rx_tcnt    <= rx_tcnt_nxt;
         rx_bcnt    <= rx_bcnt_nxt;
         rx_sr      <= rx_sr_nxt;
         rx_par_en  <= rx_par_en_nxt;
         rx_par_odd <= rx_par_odd_nxt;
         rx_perr    <= rx_perr_nxt;
         dout       <= dout_nxt;
         parity_err <= parity_err_nxt;
         frame_err  <= frame_err_nxt;
         rx_done    <= rx_done_nxt;
      end
   end

   always_comb begin
      rx_state_nxt   = rx_state;
      rx_tcnt_nxt    = rx_tcnt;
      rx_bcnt_nxt    = rx_bcnt;
      rx_sr_nxt      = rx_sr;
      rx_par_en_nxt  = rx_par_en;
      rx_par_odd_nxt = rx_par_odd;
      rx_perr_nxt    = rx_perr;
      dout_nxt       = dout;
      parity_err_nxt = parity_err;
      frame_err_nxt  = frame_err;
      rx_done_nxt    = 1'b0;

      if ((rx_state != RX_IDLE) && tick && (rx_tcnt != '0)) begin
         rx_tcnt_nxt = rx_tcnt - TC_W'(1);
      end

      case (rx_state)
         RX_IDLE: begin
            if (!rx_line) begin
               rx_state_nxt = RX_START;
               rx_tcnt_nxt  = TC_HALF;
            end
         end
         RX_START: begin
            if (rx_tc) begin
               if (!rx_line) begin
                  rx_state_nxt   = RX_DATA;
                  rx_tcnt_nxt    = TC_BIT;
                  rx_bcnt_nxt    = BC_LAST;
                  rx_par_en_nxt  = par_enabled(pm_in);
                  rx_par_odd_nxt = (pm_in == PAR_ODD);
                  rx_perr_nxt    = 1'b0;
               end else begin
                  // Glitch: drop back without touching any result.
                  rx_state_nxt = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (rx_tc) begin
               rx_sr_nxt   = {rx_line, rx_sr[DBITS-1:1]};
               rx_tcnt_nxt = TC_BIT;
               if (rx_bcnt == '0) begin
                  rx_state_nxt = rx_par_en ? RX_PARITY : RX_STOP;
                  rx_tcnt_nxt  = rx_par_en ? TC_BIT : TC_STOP;
               end else begin
                  rx_bcnt_nxt = rx_bcnt - BC_W'(1);
               end
            end
         end
         RX_PARITY: begin
            if (rx_tc) begin
               rx_perr_nxt  = rx_line ^ (^rx_sr) ^ rx_par_odd;
               rx_state_nxt = RX_STOP;
               rx_tcnt_nxt  = TC_STOP;
            end
         end
         RX_STOP: begin
            if (rx_tc) begin
               dout_nxt       = rx_sr;
               parity_err_nxt = rx_par_en & rx_perr;
               frame_err_nxt  = !rx_line;
               rx_done_nxt    = 1'b1;
               rx_state_nxt   = RX_IDLE;
            end
         end
         default: begin
            rx_state_nxt = RX_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_cfg_top.sv
module tb_uart_cfg_top;
   import uart_pkg::*;

   localparam int DBITS    = 8;
   localparam int SB_TICKS = 16;
   localparam int DIV_W    = 11;
   localparam int BIT_CYC  = 64;   // br_div = 3 -> 4 cycles/tick, 16 ticks/bit

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [DIV_W-1:0] br_div = DIV_W'(3);
   logic [1:0]       par_mode = 2'b00;
   logic             lb = 1'b0;
   logic             tx_start = 1'b0;
   logic [DBITS-1:0] din = '0;
   logic             tx, tx_busy, tx_done;
   logic             rx = 1'b1;
   logic [DBITS-1:0] dout;
   logic             rx_done, parity_err, frame_err;

   uart_cfg_top #(
      .DBITS    (DBITS),
      .SB_TICKS (SB_TICKS),
      .DIV_W    (DIV_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .br_div     (br_div),
      .par_mode   (par_mode),
      .lb         (lb),
      .tx_start   (tx_start),
      .din        (din),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .rx         (rx),
      .dout       (dout),
      .rx_done    (rx_done),
      .parity_err (parity_err),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txdone = 0;
   int n_rxdone = 0;
   logic decode_en = 1'b1;

   typedef struct {
      logic [DBITS-1:0] data;
      logic             perr;
      logic             ferr;
   } rx_exp_t;

   typedef struct {
      logic [DBITS-1:0] data;
      logic [1:0]       pm;
      int unsigned      t0;
   } tx_exp_t;

   rx_exp_t rx_q[$];
   rx_exp_t last_rx;
   tx_exp_t txd_q[$];
   tx_exp_t txf_q[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: parity bit that makes the total count of ones even/odd.
   function automatic logic has_par(input logic [1:0] pm);
      return (pm == 2'b01) || (pm == 2'b10);
   endfunction

   function automatic logic model_par(input logic [DBITS-1:0] d, input logic [1:0] pm);
      int ones;
      ones = $countones(d);
      if (pm == 2'b01) return (ones % 2) == 1;
      return ((ones + 1) % 2) == 1;
   endfunction

   function automatic int frame_cycles(input logic [1:0] pm);
      return BIT_CYC * (1 + DBITS + (has_par(pm) ? 1 : 0)) + BIT_CYC * SB_TICKS / OVERSAMPLE;
   endfunction

   // ---------------------------------------------------------------- monitors

   initial begin : rx_mon
      rx_exp_t e;
      forever begin
         @(negedge clk);
         if (rst && rx_done) begin
            n_rxdone++;
            if (rx_q.size() == 0) begin
               check("rx_done_unexpected", 1, 0);
            end else begin
               e = rx_q.pop_front();
               last_rx = e;
               check("rx_dout", 32'(dout), 32'(e.data));
               check("rx_parity_err", 32'(parity_err), 32'(e.perr));
               check("rx_frame_err", 32'(frame_err), 32'(e.ferr));
            end
         end
      end
   end

   initial begin : txdone_mon
      tx_exp_t e;
      int lat, nom;
      forever begin
         @(negedge clk);
         if (rst && tx_done) begin
            n_txdone++;
            if (txd_q.size() == 0) begin
               check("tx_done_unexpected", 1, 0);
            end else begin
               e = txd_q.pop_front();
               lat = int'(cyc - e.t0);
               nom = frame_cycles(e.pm);
               n_cmp++;
               // Free-running tick phase puts the first tick 0..3 cycles late.
               if (lat < nom - 2 || lat > nom + 1) begin
                  n_bad++;
                  $display("FAIL tx_done_latency: got %0d cycles, expected %0d-%0d", lat, nom - 2, nom + 1);
               end
            end
         end
      end
   end

   // Decodes the tx line independently, sampling mid-bit at 64 cycles/bit.
   initial begin : tx_decoder
      tx_exp_t          e;
      logic [DBITS-1:0] got;
      forever begin
         @(negedge clk);
         if (decode_en && rst && (tx == 1'b0)) begin
            if (txf_q.size() == 0) begin
               check("tx_frame_unexpected", 1, 0);
               e.data = '0;
               e.pm   = 2'b00;
               e.t0   = 0;
            end else begin
               e = txf_q.pop_front();
            end
            repeat (BIT_CYC / 2) @(negedge clk);
            check("tx_start_bit", 32'(tx), 0);
            for (int i = 0; i < DBITS; i++) begin
               repeat (BIT_CYC) @(negedge clk);
               got[i] = tx;
            end
            check("tx_data", 32'(got), 32'(e.data));
            if (has_par(e.pm)) begin
               repeat (BIT_CYC) @(negedge clk);
               check("tx_parity_bit", 32'(tx), 32'(model_par(e.data, e.pm)));
            end
            repeat (BIT_CYC) @(negedge clk);
            check("tx_stop_bit", 32'(tx), 1);
         end
      end
   end

   initial begin : watchdog
      repeat (90000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus

   task automatic send_tx(input logic [DBITS-1:0] d, input logic [1:0] pm, input logic expect_done);
      tx_exp_t e;
      @(negedge clk);
      din      = d;
      par_mode = pm;
      tx_start = 1'b1;
      e.data = d;
      e.pm   = pm;
      e.t0   = cyc;
      if (expect_done) txd_q.push_back(e);
      if (decode_en) txf_q.push_back(e);
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic push_rx(input logic [DBITS-1:0] d, input logic pe, input logic fe);
      rx_exp_t e;
      e.data = d;
      e.perr = pe;
      e.ferr = fe;
      rx_q.push_back(e);
   endtask

   task automatic send_rx(input logic [DBITS-1:0] d, input logic [1:0] pm, input logic pbit, input logic sbit);
      par_mode = pm;
      rx = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < DBITS; i++) begin
         rx = d[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      if (has_par(pm)) begin
         rx = pbit;
         repeat (BIT_CYC) @(negedge clk);
      end
      rx = sbit;
      // A low stop is released early so it is not mistaken for a new start bit.
      if (sbit) repeat (BIT_CYC * SB_TICKS / OVERSAMPLE) @(negedge clk);
      else      repeat (48) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((tx_busy || rx_q.size() != 0 || txd_q.size() != 0 || txf_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= 3000) begin
         n_bad++;
         $display("FAIL wait_idle: timeout, rx_q=%0d txd_q=%0d txf_q=%0d busy=%0b", rx_q.size(), txd_q.size(), txf_q.size(), tx_busy);
      end
      repeat (100) @(negedge clk);
   endtask

   task automatic check_hold();
      check("hold_dout", 32'(dout), 32'(last_rx.data));
      check("hold_parity_err", 32'(parity_err), 32'(last_rx.perr));
      check("hold_frame_err", 32'(frame_err), 32'(last_rx.ferr));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx"}, 32'(tx), 1);
      check({tag, "_tx_busy"}, 32'(tx_busy), 0);
      check({tag, "_tx_done"}, 32'(tx_done), 0);
      check({tag, "_rx_done"}, 32'(rx_done), 0);
      check({tag, "_dout"}, 32'(dout), 0);
      check({tag, "_parity_err"}, 32'(parity_err), 0);
      check({tag, "_frame_err"}, 32'(frame_err), 0);
   endtask

   initial begin : main
      logic [DBITS-1:0] d, d2;
      logic [1:0]       pm;
      logic             pb, sb;
      int               snap_rx, snap_tx;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_tx_high", 32'(tx), 1);

      // Loopback, no parity, 8'hA5
      lb = 1'b1;
      push_rx(8'hA5, 1'b0, 1'b0);
      send_tx(8'hA5, 2'b00, 1'b1);
      wait_idle();
      check_hold();

      // Loopback, 8'h07 even then odd parity
      push_rx(8'h07, 1'b0, 1'b0);
      send_tx(8'h07, 2'b01, 1'b1);
      wait_idle();
      push_rx(8'h07, 1'b0, 1'b0);
      send_tx(8'h07, 2'b10, 1'b1);
      wait_idle();

      // External rx: 8'h3C, even parity mode, wrong parity bit
      lb = 1'b0;
      push_rx(8'h3C, has_par(2'b01) && (1'b1 != model_par(8'h3C, 2'b01)), 1'b0);
      send_rx(8'h3C, 2'b01, 1'b1, 1'b1);
      wait_idle();
      check_hold();

      // Stop bit low, then a clean frame clears frame_err
      d = DBITS'($urandom);
      push_rx(d, 1'b0, 1'b1);
      send_rx(d, 2'b00, 1'b0, 1'b0);
      wait_idle();
      check_hold();
      d = DBITS'($urandom);
      push_rx(d, 1'b0, 1'b0);
      send_rx(d, 2'b00, 1'b0, 1'b1);
      wait_idle();
      check_hold();

      // False start: 4 ticks low
      snap_rx = n_rxdone;
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      check("false_start_no_rx_done", 32'(n_rxdone), 32'(snap_rx));

      // tx_start while busy is ignored
      lb = 1'b1;
      snap_tx = n_txdone;
      d = DBITS'($urandom);
      push_rx(d, 1'b0, 1'b0);
      send_tx(d, 2'b00, 1'b1);
      repeat (100) @(negedge clk);
      check("busy_during_frame", 32'(tx_busy), 1);
      din      = ~d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      wait_idle();
      repeat (800) @(negedge clk);
      check("ignored_start_tx_done_count", 32'(n_txdone - snap_tx), 1);
      check_hold();

      // Randomised frames: loopback, or simultaneous independent TX and RX
      for (int it = 0; it < 8; it++) begin
         d  = DBITS'($urandom);
         pm = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            lb = 1'b1;
            push_rx(d, 1'b0, 1'b0);
            send_tx(d, pm, 1'b1);
         end else begin
            lb = 1'b0;
            d2 = DBITS'($urandom);
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 3) != 0);
            push_rx(d2, has_par(pm) && (pb != model_par(d2, pm)), !sb);
            fork
               send_tx(d, pm, 1'b1);
               send_rx(d2, pm, pb, sb);
            join
         end
         wait_idle();
         check_hold();
      end

      // Reset in the middle of a TX data phase (loopback also mid-frame)
      lb = 1'b1;
      decode_en = 1'b0;
      snap_tx = n_txdone;
      snap_rx = n_rxdone;
      send_tx(8'hC3, 2'b00, 1'b0);
      repeat (300) @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (1000) @(negedge clk);
      check("post_reset_no_tx_done", 32'(n_txdone), 32'(snap_tx));
      check("post_reset_no_rx_done", 32'(n_rxdone), 32'(snap_rx));
      check("post_reset_tx_idle", 32'(tx), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_cfg_top.md
UART_CFG_TOP -- requirements
Module: uart_cfg_top

Interface
REQ-001 Parameter DBITS, default 8, data bits per frame (legal 5..9).
REQ-002 Parameter SB_TICKS, default 16, stop-bit length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter DIV_W, default 11, baud divisor width.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 br_div  input  DIV_W  tick period minus one, in clk cycles; tick rate is 16x the baud rate.
REQ-007 par_mode  input  2  00 = none, 01 = even, 10 = odd, 11 = none.
REQ-008 lb  input  1  loopback: receiver input taken from internal tx instead of rx.
REQ-009 tx_start  input  1  request to send din.
REQ-010 din  input  DBITS  transmit data.
REQ-011 tx  output  1  serial line out, idle high.
REQ-012 tx_busy  output  1  transmitter not IDLE.
REQ-013 tx_done  output  1  one-cycle pulse at end of stop bit.
REQ-014 rx  input  1  serial line in, asynchronous to clk.
REQ-015 dout  output  DBITS  last received data.
REQ-016 rx_done  output  1  one-cycle pulse, frame received.
REQ-017 parity_err  output  1  parity mismatch on last frame (0 when par_mode is none).
REQ-018 frame_err  output  1  stop bit sampled low on last frame.

Function
REQ-019 Baud counter runs 0..br_div, then wraps to 0; tick pulses one cycle on wrap; br_div=0 gives a tick every cycle; a count above a newly written br_div wraps on the next cycle.
REQ-020 TX FSM states: IDLE, START, DATA, PARITY, STOP; tx=1 in IDLE.
REQ-021 tx_start in IDLE latches din and par_mode and enters START on the next cycle; tx_start outside IDLE is ignored.
REQ-022 START, each DATA bit and PARITY each last 16 ticks; data is sent LSB first; PARITY is skipped when par_mode is none.
REQ-023 Even parity: XOR of the data bits; odd parity: its inverse.
REQ-024 STOP drives 1 for SB_TICKS ticks, then pulses tx_done and returns to IDLE in the same cycle.
REQ-025 rx passes through a two-flop synchroniser; lb=1 selects tx ahead of the synchroniser.
REQ-026 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-027 Synchronised line low in IDLE enters START; at tick 7 the line must still be low, else return to IDLE with no outputs changed.
REQ-028 par_mode is latched by RX at start-bit confirmation.
REQ-029 Each subsequent bit is sampled at its 16th tick (mid-bit) and shifted in LSB first.
REQ-030 STOP samples the line after SB_TICKS ticks; low sets frame_err.
REQ-031 At STOP end, dout, parity_err and frame_err update and rx_done pulses in the same cycle; flags hold until the next rx_done.
REQ-032 A frame with errors still updates dout.
REQ-033 TX and RX operate independently and may be active simultaneously.

Reset
REQ-034 rst low asynchronously forces: both FSMs to IDLE, counters 0, tx=1, tx_busy=0, tx_done=0, rx_done=0, dout=0, parity_err=0, frame_err=0, synchroniser flops to 1.
REQ-035 Reset mid-frame abandons the frame; no done pulse is generated after release.

Structure
REQ-036 Package uart_pkg holds par_mode_t, tx_state_t, rx_state_t and the constant OVERSAMPLE=16.
REQ-037 The baud generator is sub-module uart_baud_gen; TX and RX FSMs live in uart_cfg_top.

Verification
Common setup for all scenarios: DBITS=8, SB_TICKS=16, br_div=3 (64 cycles per bit).
REQ-038 lb=1, par_mode=00, din=8'hA5 -> tx_done 640 cycles after start; rx_done with dout=8'hA5; both error flags 0.
REQ-039 lb=1, din=8'h07, par_mode=01 then 10 -> parity bit 1 then 0 on tx; parity_err=0 both times.
REQ-040 lb=0, rx drives 8'h3C with even mode but parity bit 1 -> rx_done, dout=8'h3C, parity_err=1.
REQ-041 lb=0, rx stop bit driven 0 -> rx_done, frame_err=1; next clean frame clears frame_err.
REQ-042 rx low for 4 ticks then high -> no rx_done, RX returns to IDLE; a tx_start pulse while tx_busy=1 is ignored.
REQ-043 rst low during DATA -> tx=1 and all outputs at reset values within the same cycle; no tx_done after release.
